// File: rtl/huff_pkg.sv
// Shared types and default sizes for the Huffman store controller.
// The state enum is visible to every module that imports this package.
package huff_pkg;

  localparam int MAX_TEXT_D = 1024;
  localparam int CODE_W_D   = 16;
  localparam int LEN_W_D    = 5;

  typedef enum logic [2:0] {
    ACCEPT,
    SHIFT,
    FINISH,
    RD_REQ,
    RD_CAP,
    RD_OUT
  } store_ctrl_state_e;

endpackage

// File: rtl/store_ctrl_code_shifter.sv
// Holds one Huffman code word and emits it MSB-first, one bit per shift.
// The code is left-aligned on load so the current bit is always the top bit.
module code_shifter
  import huff_pkg::*;
#(
  parameter int CODE_W = CODE_W_D,
  parameter int LEN_W  = LEN_W_D
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              shift_i,
  output logic              bit_o,
  output logic              last_o
);

  logic [CODE_W-1:0] code_q;
  logic [LEN_W-1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      code_q <= code_i << (CODE_W - int'(len_i));
      cnt_q  <= len_i;
    end else if (shift_i && cnt_q != '0) begin
      code_q <= code_q << 1;
      cnt_q  <= cnt_q - LEN_W'(1);
    end
  end

  assign bit_o  = code_q[CODE_W-1];
  assign last_o = cnt_q == LEN_W'(1);

endmodule

// File: rtl/store_ctrl.sv
// Writes Huffman code bits into a bit store, then drains the stored
// message to a serial valid/ready stream one bit at a time.
module store_ctrl
  import huff_pkg::*;
#(
  parameter int MAX_TEXT = MAX_TEXT_D,
  parameter int CODE_W   = CODE_W_D,
  parameter int LEN_W    = LEN_W_D
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sym_valid_i,
  output logic                       sym_ready_o,
  input  logic [CODE_W-1:0]          code_i,
  input  logic [LEN_W-1:0]           len_i,
  input  logic                       eom_i,
  output logic                       st_receive_o,
  output logic                       st_text_o,
  output logic                       st_finish_o,
  input  logic                       st_done_i,
  output logic                       st_flag_bit_o,
  input  logic                       st_bit_i,
  output logic                       out_valid_o,
  output logic                       out_bit_o,
  input  logic                       out_ready_i,
  output logic [$clog2(MAX_TEXT):0]  total_bits_o,
  output logic                       overflow_o,
  output logic                       busy_o
);

  localparam int CNT_W = $clog2(MAX_TEXT) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_TEXT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  store_ctrl_state_e state;
  logic              eom_pend;
  logic [CNT_W-1:0]  remaining;
  logic              full;
  logic              load;
  logic              shifting;
  logic              bit_cur;
  logic              last;

  assign full     = total_bits_o == FULL;
  assign load     = state == ACCEPT && sym_valid_i && len_i != '0;
  assign shifting = state == SHIFT;

  code_shifter #(
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W)
  ) u_shift (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .code_i  (code_i),
    .len_i   (len_i),
    .shift_i (shifting),
    .bit_o   (bit_cur),
    .last_o  (last)
  );

  assign sym_ready_o   = state == ACCEPT;
  assign busy_o        = state != ACCEPT;
  assign st_receive_o  = shifting && !full;
  assign st_text_o     = shifting && bit_cur;
  assign st_finish_o   = state == FINISH;
  assign st_flag_bit_o = state == RD_REQ;
  assign out_valid_o   = state == RD_OUT;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ACCEPT;
      eom_pend     <= 1'b0;
      remaining    <= '0;
      total_bits_o <= '0;
      overflow_o   <= 1'b0;
      out_bit_o    <= 1'b0;
    end else begin
      unique case (state)
        ACCEPT: begin
          // zero-length symbols are swallowed without leaving ACCEPT
          if (load) begin
            eom_pend <= eom_i;
            state    <= SHIFT;
          end else if (eom_i) begin
            state <= FINISH;
          end
        end
        SHIFT: begin
          if (full) overflow_o <= 1'b1;
          else total_bits_o <= total_bits_o + ONE;
          if (last) state <= eom_pend ? FINISH : ACCEPT;
        end
        FINISH: begin
          if (st_done_i) begin
            eom_pend  <= 1'b0;
            remaining <= total_bits_o;
            if (total_bits_o != '0) begin
              state <= RD_REQ;
            end else begin
              state        <= ACCEPT;
              total_bits_o <= '0;
              overflow_o   <= 1'b0;
            end
          end
        end
        RD_REQ: state <= RD_CAP;
        RD_CAP: begin
          out_bit_o <= st_bit_i;
          state     <= RD_OUT;
        end
        RD_OUT: begin
          if (out_ready_i) begin
            remaining <= remaining - ONE;
            if (remaining <= ONE) begin
              state        <= ACCEPT;
              total_bits_o <= '0;
              overflow_o   <= 1'b0;
              eom_pend     <= 1'b0;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_store_ctrl.sv
// Testbench for store_ctrl: bit-store model, directed vectors, corner
// sequences and random messages checked against a bit-list reference.
module tb_store_ctrl;

  localparam int MT = 1024;
  localparam int CW = 16;
  localparam int LW = 5;
  localparam int NW = $clog2(MT) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          sym_valid_i;
  logic          sym_ready_o;
  logic [CW-1:0] code_i;
  logic [LW-1:0] len_i;
  logic          eom_i;
  logic          st_receive_o;
  logic          st_text_o;
  logic          st_finish_o;
  logic          st_done_i;
  logic          st_flag_bit_o;
  logic          st_bit_i;
  logic          out_valid_o;
  logic          out_bit_o;
  logic          out_ready_i;
  logic [NW-1:0] total_bits_o;
  logic          overflow_o;
  logic          busy_o;

  store_ctrl #(
    .MAX_TEXT (MT),
    .CODE_W   (CW),
    .LEN_W    (LW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sym_valid_i   (sym_valid_i),
    .sym_ready_o   (sym_ready_o),
    .code_i        (code_i),
    .len_i         (len_i),
    .eom_i         (eom_i),
    .st_receive_o  (st_receive_o),
    .st_text_o     (st_text_o),
    .st_finish_o   (st_finish_o),
    .st_done_i     (st_done_i),
    .st_flag_bit_o (st_flag_bit_o),
    .st_bit_i      (st_bit_i),
    .out_valid_o   (out_valid_o),
    .out_bit_o     (out_bit_o),
    .out_ready_i   (out_ready_i),
    .total_bits_o  (total_bits_o),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  bit wr_q[$];
  bit rd_q[$];
  bit exp_q[$];
  int exp_sum;
  int flags;
  int fins;
  logic [NW-1:0] fin_total;
  logic fin_ovf;

  logic sbuf[2048];
  int   wptr;
  int   rptr;
  bit   new_msg;
  bit   done_en = 1'b1;
  int   rmode = 0;

  // store model and output monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      wptr = 0;
      rptr = 0;
      new_msg = 1'b0;
      st_done_i = 1'b0;
    end else begin
      if (st_receive_o) begin
        if (new_msg) begin
          wptr = 0;
          new_msg = 1'b0;
        end
        if (wptr < 2048) sbuf[wptr] = st_text_o;
        wptr++;
        wr_q.push_back(st_text_o);
      end
      if (st_finish_o) begin
        fins++;
        fin_total = total_bits_o;
        fin_ovf = overflow_o;
        rptr = 0;
        new_msg = 1'b1;
      end
      st_done_i = st_finish_o && done_en;
      if (st_flag_bit_o) begin
        flags++;
        st_bit_i = (rptr < 2048) ? sbuf[rptr] : 1'b0;
        rptr++;
      end
      if (out_valid_o && out_ready_i) rd_q.push_back(out_bit_o);
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rmode == 1) out_ready_i = 1'($urandom_range(0, 1));
    else if (rmode == 0) out_ready_i = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rd_q.delete();
    exp_q.delete();
    exp_sum = 0;
    flags = 0;
    fins = 0;
    fin_total = '0;
    fin_ovf = 1'b0;
  endtask

  task automatic send(input logic v, input logic [CW-1:0] c,
                      input logic [LW-1:0] l, input logic e);
    int n;
    n = 0;
    sym_valid_i = v;
    code_i = c;
    len_i = l;
    eom_i = e;
    do begin
      @(negedge clk_i);
      n++;
    end while (!sym_ready_o && n < 5000);
    @(posedge clk_i);
    #1;
    sym_valid_i = 1'b0;
    eom_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy_o && n < 20000);
    check("idle", busy_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  // reference: the message is the MSB-first concatenation, capped at MT
  function automatic void model_sym(input logic [CW-1:0] c,
                                    input logic [LW-1:0] l);
    for (int i = int'(l) - 1; i >= 0; i--)
      if (exp_q.size() < MT) exp_q.push_back(c[i]);
    exp_sum += int'(l);
  endfunction

  function automatic logic [63:0] pack(input int sel);
    logic [63:0] v;
    v = '0;
    if (sel == 0) foreach (wr_q[i]) v = {v[62:0], wr_q[i]};
    else foreach (rd_q[i]) v = {v[62:0], rd_q[i]};
    return v;
  endfunction

  function automatic int diffs(input int sel);
    int n;
    n = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (sel == 0) begin
        if (i >= wr_q.size() || wr_q[i] != exp_q[i]) n++;
      end else if (i >= rd_q.size() || rd_q[i] != exp_q[i]) n++;
    end
    return n;
  endfunction

  task automatic compare_msg(input string nm);
    check({nm, " wr_n"}, wr_q.size(), exp_q.size());
    check({nm, " wr_bits"}, diffs(0), 0);
    check({nm, " rd_n"}, rd_q.size(), exp_q.size());
    check({nm, " rd_bits"}, diffs(1), 0);
    check({nm, " flags"}, flags, exp_q.size());
    check({nm, " total"}, fin_total, exp_q.size());
    check({nm, " ovf"}, fin_ovf, exp_sum > MT);
  endtask

  typedef struct {
    logic [CW-1:0] code;
    logic [LW-1:0] len;
    int            n;
    logic [CW-1:0] val;
  } vec_t;

  vec_t vt[9];
  logic [CW-1:0] rc;
  logic [LW-1:0] rl;
  logic hb;
  bit stable;
  int ns;
  bit sep;
  int n;

  initial begin
    vt[0] = '{16'h0005, 5'd3,  3,  16'h0005};
    vt[1] = '{16'h000F, 5'd4,  4,  16'h000F};
    vt[2] = '{16'h0001, 5'd1,  1,  16'h0001};
    vt[3] = '{16'h8000, 5'd16, 16, 16'h8000};
    vt[4] = '{16'hABCD, 5'd16, 16, 16'hABCD};
    vt[5] = '{16'h0000, 5'd5,  5,  16'h0000};
    vt[6] = '{16'h0002, 5'd2,  2,  16'h0002};
    vt[7] = '{16'h00F2, 5'd3,  3,  16'h0002};
    vt[8] = '{16'hFFFF, 5'd0,  0,  16'h0000};

    rst_ni = 1'b0;
    sym_valid_i = 1'b0;
    code_i = '0;
    len_i = '0;
    eom_i = 1'b0;
    st_bit_i = 1'b0;
    out_ready_i = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk_i);
    check("rst outs", {st_receive_o, st_text_o, st_finish_o, st_flag_bit_o,
          out_valid_o, out_bit_o, overflow_o, busy_o, total_bits_o}, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst ready", sym_ready_o, 1);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 9; i++) begin
      clear_mon();
      send(1'b1, vt[i].code, vt[i].len, 1'b1);
      wait_idle();
      check($sformatf("v%0d wr_n", i), wr_q.size(), vt[i].n);
      check($sformatf("v%0d wr_val", i), pack(0), vt[i].val);
      check($sformatf("v%0d total", i), fin_total, vt[i].n);
      check($sformatf("v%0d fin", i), fins > 0, 1);
      check($sformatf("v%0d rd_val", i), pack(1), vt[i].val);
      check($sformatf("v%0d flags", i), flags, vt[i].n);
    end

    clear_mon();
    done_en = 1'b0;
    send(1'b0, '0, '0, 1'b1);
    repeat (5) @(negedge clk_i);
    check("eom0 finish held", st_finish_o, 1);
    check("eom0 total", total_bits_o, 0);
    done_en = 1'b1;
    wait_idle();
    check("eom0 flags", flags, 0);
    check("eom0 rd_n", rd_q.size(), 0);

    rmode = 2;
    out_ready_i = 1'b0;
    clear_mon();
    send(1'b1, 16'h000D, 5'd4, 1'b1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!out_valid_o && n < 200);
    check("hold valid", out_valid_o, 1);
    hb = out_bit_o;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (out_bit_o !== hb || out_valid_o !== 1'b1) stable = 1'b0;
    end
    check("hold stable", stable, 1);
    check("hold first bit", hb, 1);
    check("hold flags", flags, 1);
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    rmode = 0;
    wait_idle();
    check("hold rd_val", pack(1), 16'h000D);
    check("hold flags tot", flags, 4);

    clear_mon();
    send(1'b1, 16'hFFFF, 5'd16, 1'b0);
    repeat (3) @(negedge clk_i);
    check("shift mid recv", st_receive_o, 1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst mid outs", {st_receive_o, st_text_o, st_finish_o,
          st_flag_bit_o, out_valid_o, out_bit_o, overflow_o, busy_o,
          total_bits_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst mid ready", sym_ready_o, 1);
    @(posedge clk_i);
    #1;

    clear_mon();
    rmode = 1;
    for (int s = 0; s < 64; s++) begin
      rc = CW'($urandom);
      model_sym(rc, 5'd16);
      send(1'b1, rc, 5'd16, 1'b0);
    end
    rc = CW'($urandom);
    model_sym(rc, 5'd6);
    send(1'b1, rc, 5'd6, 1'b0);
    send(1'b0, '0, '0, 1'b1);
    wait_idle();
    compare_msg("ovf");

    for (int m = 0; m < 25; m++) begin
      clear_mon();
      ns = $urandom_range(1, 6);
      sep = 1'($urandom_range(0, 1));
      for (int s = 0; s < ns; s++) begin
        rc = CW'($urandom);
        rl = LW'($urandom_range(0, CW));
        model_sym(rc, rl);
        send(1'b1, rc, rl, !sep && s == ns - 1);
      end
      if (sep) send(1'b0, '0, '0, 1'b1);
      wait_idle();
      compare_msg($sformatf("rnd%0d", m));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/store_ctrl.md
STORE_CTRL -- requirements
Module: store_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset named as the codebase does (clk_i, rst_ni); this polarity and synchronicity are fixed.
REQ-002 Parameter MAX_TEXT, default 1024: store buffer capacity in bits.
REQ-003 Parameter CODE_W, default 16: maximum Huffman code length.
REQ-004 Parameter LEN_W, default 5: code length field width; CNT_W = $clog2(MAX_TEXT)+1 (11 by default).
REQ-005 clk_i  in  1  clock, all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 sym_valid_i  in  1  upstream code word valid.
REQ-008 sym_ready_o  out  1  high in ACCEPT only.
REQ-009 code_i  in  CODE_W  code word, right-aligned, emitted MSB-first from bit len_i-1.
REQ-010 len_i  in  LEN_W  code length, 0..CODE_W.
REQ-011 eom_i  in  1  end-of-message, sampled in ACCEPT only.
REQ-012 st_receive_o / st_text_o / st_finish_o  out  1 each  store write strobe, write data bit, finish request.
REQ-013 st_done_i  in  1  store has latched its buffer.
REQ-014 st_flag_bit_o  out  1  one-cycle read-advance pulse to the store.
REQ-015 st_bit_i  in  1  store read bit, valid the cycle after st_flag_bit_o.
REQ-016 out_valid_o / out_bit_o  out  1 each  serial bitstream to downstream; out_ready_i  in  1  downstream accept.
REQ-017 total_bits_o  out  CNT_W  bits written this message; overflow_o  out  1  sticky overflow; busy_o  out  1  state != ACCEPT.

Function
REQ-018 FSM states: ACCEPT, SHIFT, FINISH, RD_REQ, RD_CAP, RD_OUT.
REQ-019 ACCEPT: on sym_valid_i && sym_ready_o with len_i != 0, latch code/len, go SHIFT; len_i == 0 is consumed and dropped, FSM stays in ACCEPT.
REQ-020 ACCEPT: eom_i with no handshake -> FINISH; eom_i together with a handshake sets eom_pend and the symbol is shifted first.
REQ-021 SHIFT: one bit per cycle; st_receive_o=1, st_text_o=code[cnt-1], cnt decrements, total_bits_o increments.
REQ-022 SHIFT exit: after the last bit (cnt==1), go FINISH if eom_pend, else ACCEPT; no bubble beyond this one cycle.
REQ-023 Overflow: when total_bits_o == MAX_TEXT, st_receive_o stays 0, the bit is dropped, overflow_o sets, and remaining shift cycles still elapse.
REQ-024 FINISH: st_finish_o held 1 until st_done_i=1, then clear eom_pend and load remaining=total_bits_o.
REQ-025 FINISH exit: go RD_REQ if remaining > 0; otherwise ACCEPT with counters cleared.
REQ-026 RD_REQ: st_flag_bit_o=1 for exactly one cycle, then RD_CAP.
REQ-027 RD_CAP: register st_bit_i into out_bit_o, then RD_OUT.
REQ-028 RD_OUT: out_valid_o=1 with out_bit_o stable until out_ready_i; on accept, remaining decrements.
REQ-029 RD_OUT after accept: go RD_REQ if remaining > 1, else ACCEPT with total_bits_o, overflow_o and eom_pend cleared.
REQ-030 Downstream throughput is one bit per 3 cycles minimum.
REQ-031 sym_valid_i and eom_i are ignored outside ACCEPT.

Reset
REQ-032 Reset asserted, even mid-operation, SHALL force state ACCEPT and set every registered output, total_bits_o, overflow_o, eom_pend and counters to 0.
REQ-033 sym_ready_o SHALL read 1 in the first cycle after reset release.

Structure
REQ-034 Package huff_pkg SHALL hold the state enum store_ctrl_state_e and the MAX_TEXT / CODE_W defaults.
REQ-035 Sub-module code_shifter (latch code/len, emit MSB-first, cnt, last flag) is permitted; all other logic stays flat.

Verification
REQ-036 Send code 0b101, len 3, then eom -> st_text_o = 1,0,1 on 3 consecutive cycles, total_bits_o = 3, st_finish_o asserted.
REQ-037 After st_done_i, store returns 1,0,1 with out_ready_i=1 -> out_bit_o = 1,0,1, exactly 3 st_flag_bit_o pulses, final state ACCEPT.
REQ-038 Symbol len 4 and eom in the same cycle -> 4 bits written, then FINISH; len_i=0 symbol -> no st_receive_o.
REQ-039 Write 1030 bits with MAX_TEXT=1024 -> exactly 1024 st_receive_o pulses, overflow_o=1, drain outputs 1024 bits.
REQ-040 eom with 0 bits -> FINISH, st_done_i, then ACCEPT with no st_flag_bit_o pulse.
REQ-041 Hold out_ready_i=0 for 10 cycles mid-drain -> out_bit_o stable, no extra flag pulse; reset during SHIFT -> all outputs 0 next cycle.
